// File: rtl/neg_pkg.sv
// Shared definitions for the negator self-test logic.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package neg_pkg;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Widest operand the helper function handles directly.
    localparam int NEG_MAX_W = 32;

    // Two's-complement negation (invert plus one) at full helper width;
    // callers mask the result down to their own operand width.
    function automatic logic [NEG_MAX_W-1:0] neg2c(input logic [NEG_MAX_W-1:0] x);
        return ~x + {{(NEG_MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/neg_sweep_checker.sv
// Sweeps every operand through an external negator and counts result mismatches.
// Latency: start -> done pulse after 2^WIDTH*(SETTLE+1)+1 cycles.
// Backpressure: none; start ignored while sweeping, abort returns to idle at once.
module neg_sweep_checker
    import neg_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_err_a,
    output logic             first_err_valid
);

    // Settle counter needs at least one bit even when SETTLE is 1.
    localparam int                CW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]     CNT_RELOAD = CW'(SETTLE - 1);
    localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
    localparam logic [WIDTH-1:0]  A_LAST     = '1;
    localparam logic [WIDTH-1:0]  A_ONE      = WIDTH'(1);
    localparam logic [WIDTH:0]    ERR_ONE    = (WIDTH+1)'(1);
    localparam logic [NEG_MAX_W-1:0] MASK    = NEG_MAX_W'((64'd1 << WIDTH) - 64'd1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [WIDTH:0]   r_err;
    logic [WIDTH-1:0] r_first_a;
    logic             r_first_v;

    logic             w_mismatch;
    logic [WIDTH:0]   w_err_nxt;
    logic             w_last;

    // Expected result comes from the operand we drive, never from b_in's path
    // to an output, so every output stays registered.
    assign w_mismatch = ((neg2c(NEG_MAX_W'(r_a)) ^ NEG_MAX_W'(b_in)) & MASK) != '0;
    assign w_err_nxt  = w_mismatch ? (r_err + ERR_ONE) : r_err;
    assign w_last     = (r_a == A_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort beats every other transition out of a busy state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_CHECK);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    // Operand, settle counter and result bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_cnt     <= '0;
            r_pass    <= 1'b0;
            r_err     <= '0;
            r_first_a <= '0;
            r_first_v <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_a       <= '0;
                        r_cnt     <= CNT_RELOAD;
                        r_pass    <= 1'b0;
                        r_err     <= '0;
                        r_first_a <= '0;
                        r_first_v <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_pass <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        r_pass <= 1'b0;
                    end else begin
                        r_err <= w_err_nxt;
                        if (w_mismatch && !r_first_v) begin
                            r_first_a <= r_a;
                            r_first_v <= 1'b1;
                        end
                        if (w_last) begin
                            // Verdict is valid in the same cycle done goes high.
                            r_pass <= (w_err_nxt == '0);
                        end else begin
                            r_a   <= r_a + A_ONE;
                            r_cnt <= CNT_RELOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_pass <= abort ? 1'b0 : (r_err == '0);
                end
                default: begin
                    r_pass <= 1'b0;
                end
            endcase
        end
    end

    assign a_out           = r_a;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_a     = r_first_a;
    assign first_err_valid = r_first_v;

endmodule

// File: tb/tb_neg_sweep_checker.sv
// Self-checking bench for neg_sweep_checker with table-driven negator faults.
// Latency: expects done 33 cycles after start at default parameters.
// Backpressure: n/a; start/abort driven directly.
module tb_neg_sweep_checker;

    localparam int W    = 4;
    localparam int S    = 1;
    localparam int NOPS = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] a_out;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         pass;
    logic [W:0]   err_count;
    logic [W-1:0] first_err_a;
    logic         first_err_valid;

    logic [W-1:0] lut [NOPS];

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Negator stand-in: whatever the current fault table says.
    assign b_in = lut[a_out];

    neg_sweep_checker #(.WIDTH(W), .SETTLE(S)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .a_out           (a_out),
        .b_in            (b_in),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_a     (first_err_a),
        .first_err_valid (first_err_valid)
    );

    function automatic int negv(input int a);
        return (NOPS - a) % NOPS;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: sweep position is a cycle index k; operand k/(S+1)
    // is judged on the last cycle of its slot.
    bit m_run, m_done, m_busy, m_pass, m_fv;
    int m_k, m_err, m_fa, m_a, m_op;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_busy = 0; m_pass = 0; m_fv = 0;
            m_k = 0; m_err = 0; m_fa = 0; m_a = 0;
        end else if (m_done) begin
            m_done = 0;
            if (abort) m_pass = 0;
        end else if (!m_run) begin
            if (start && !abort) begin
                m_run = 1; m_busy = 1; m_k = 0; m_err = 0;
                m_fa = 0; m_fv = 0; m_pass = 0; m_a = 0;
            end
        end else if (abort) begin
            m_run = 0; m_busy = 0; m_pass = 0;
        end else begin
            if (m_k % (S + 1) == S) begin
                m_op = m_k / (S + 1);
                if (int'(lut[m_op]) != negv(m_op)) begin
                    m_err++;
                    if (!m_fv) begin
                        m_fv = 1;
                        m_fa = m_op;
                    end
                end
                if (m_op == NOPS - 1) begin
                    m_run = 0; m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                end else begin
                    m_a = m_op + 1;
                end
            end
            m_k++;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_a_out", a_out, m_a);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_done", done, m_done);
        chk("cyc_pass", pass, m_pass);
        chk("cyc_err_count", err_count, m_err);
        chk("cyc_first_err_a", first_err_a, m_fa);
        chk("cyc_first_err_valid", first_err_valid, m_fv);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lut(input int mode);
        for (int a = 0; a < NOPS; a++) begin
            case (mode)
                0: lut[a] = W'(negv(a));
                1: lut[a] = '0;
                2: lut[a] = W'(~a);
                3: lut[a] = W'(a);
                default: lut[a] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, NOPS - 1))
                                                              : W'(negv(a));
            endcase
        end
    endtask

    // Pulse start, optionally re-pulse start / pulse abort at given cycles,
    // report the cycle done was first seen (0 if never), then drain to idle.
    task automatic run_sweep(input int restart_at, input int abort_at, output int dcyc);
        dcyc  = 0;
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (restart_at > 0 && n == restart_at) start = 1'b1;
            if (restart_at > 0 && n == restart_at + 1) start = 1'b0;
            if (abort_at > 0 && n == abort_at) abort = 1'b1;
            if (abort_at > 0 && n == abort_at + 1) begin
                abort = 1'b0;
                chk("abort_busy_low", busy, 0);
            end
            if (done && dcyc == 0) dcyc = n;
        end
        for (int n = 0; n < 80 && (busy || done); n++) tick();
        if (busy || done) chk("drain_timeout", 1, 0);
    endtask

    int d;
    int exp_err;
    int exp_fa;
    int ab;
    int rs;

    initial begin
        for (int a = 0; a < NOPS; a++) lut[a] = W'(negv(a));
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_a_out", a_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first_valid", first_err_valid, 0);
        rst_n = 1'b1;
        tick();

        // Golden negator, with a stray start at cycle 10.
        set_lut(0);
        run_sweep(10, 0, d);
        chk("gold_done_cycle", d, 33);
        chk("gold_pass", pass, 1);
        chk("gold_err", err_count, 0);
        chk("gold_first_valid", first_err_valid, 0);

        // Stuck-at-zero result: only a=0 agrees.
        set_lut(1);
        run_sweep(0, 0, d);
        chk("stuck0_done_cycle", d, 33);
        chk("stuck0_err", err_count, 15);
        chk("stuck0_first_a", first_err_a, 1);
        chk("stuck0_pass", pass, 0);

        // Missing +1: every operand wrong.
        set_lut(2);
        run_sweep(0, 0, d);
        chk("inv_err", err_count, 16);
        chk("inv_first_a", first_err_a, 0);
        chk("inv_first_valid", first_err_valid, 1);
        chk("inv_pass", pass, 0);

        // Pass-through: only 0 and 8 are their own negation.
        set_lut(3);
        run_sweep(0, 0, d);
        chk("ident_err", err_count, 14);
        chk("ident_first_a", first_err_a, 1);
        chk("ident_pass", pass, 0);

        // Abort mid-sweep: done must never pulse.
        set_lut(0);
        run_sweep(0, 12, d);
        chk("abort_no_done", d, 0);
        chk("abort_pass", pass, 0);

        // start and abort together in idle: stay idle.
        start = 1'b1; abort = 1'b1;
        tick(); tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        tick();

        // Random fault tables, random stray starts and occasional aborts.
        repeat (8) begin
            set_lut(4);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 34)) : 0;
            rs = int'($urandom_range(2, 30));
            if (ab > 0 && rs > ab) rs = 0;
            run_sweep(rs, ab, d);
            if (ab == 0) begin
                exp_err = 0;
                exp_fa  = 0;
                for (int a = NOPS - 1; a >= 0; a--) begin
                    if (int'(lut[a]) != negv(a)) begin
                        exp_err++;
                        exp_fa = a;
                    end
                end
                chk("rnd_done_cycle", d, 33);
                chk("rnd_err", err_count, exp_err);
                chk("rnd_first_a", first_err_a, exp_fa);
                chk("rnd_pass", pass, (exp_err == 0) ? 1 : 0);
            end
        end

        // Asynchronous reset in the middle of a failing sweep.
        set_lut(1);
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("arst_a_out", a_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_count, 0);
        chk("arst_first_a", first_err_a, 0);
        chk("arst_first_valid", first_err_valid, 0);
        chk("arst_pass", pass, 0);
        chk("arst_done", done, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        set_lut(0);
        run_sweep(0, 0, d);
        chk("post_rst_done_cycle", d, 33);
        chk("post_rst_pass", pass, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/neg_sweep_checker.md
Name: neg_sweep_checker

Overview:
- Sequential self-test stage that sits around the 4-bit two's-complement negator (invert-plus-one).
- Upstream role: drives the negator's operand input through every code 0..2^W-1 in turn.
- Downstream role: samples the negator's result for each operand and compares it with the expected value.
- Reports the error count, the first failing operand, and a pass/done indication, so the negator can be validated on the board without a waveform viewer.

Parameters:
- WIDTH, 4, operand width of the negator under test (>=2).
- SETTLE, 1, cycles to wait after changing a_out before sampling b_in (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  stop the sweep; return to IDLE without asserting done.
- a_out  out  WIDTH  operand driven to the negator input.
- b_in  in  WIDTH  negator result; combinational function of a_out.
- busy  out  1  high in WAIT and CHECK.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  valid from done onward: 1 iff err_count==0.
- err_count  out  WIDTH+1  number of mismatching operands in the last or current sweep.
- first_err_a  out  WIDTH  operand of the first mismatch.
- first_err_valid  out  1  set when the first mismatch is recorded.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; a_out=0; busy=0; done=0; pass=0; err_count=0; first_err_a=0; first_err_valid=0; settle counter=0.
  - Applies immediately, including mid-sweep.
- All outputs are registered; no combinational path from b_in to any output.
- Expected value: exp = (~a_out + 1) mod 2^WIDTH, computed internally from a_out. Special cases: exp(0)=0; exp(2^(WIDTH-1)) = 2^(WIDTH-1).
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - busy=0.
  - On start=1: a_out<=0, err_count<=0, first_err_valid<=0, first_err_a<=0, pass<=0, settle counter<=SETTLE-1, go to WAIT.
- WAIT:
  - busy=1; a_out is held.
  - If counter==0, go to CHECK; otherwise decrement.
  - Total time in WAIT is SETTLE cycles.
- CHECK (single cycle):
  - If b_in != exp: err_count<=err_count+1.
  - On a mismatch with first_err_valid==0: also first_err_a<=a_out and first_err_valid<=1.
  - If a_out == 2^WIDTH-1: go to DONE; a_out holds.
  - Else: a_out<=a_out+1, reload counter to SETTLE-1, go to WAIT.
- DONE (single cycle):
  - done=1; busy=0; pass<=(err_count==0); then go to IDLE.
  - pass, err_count, first_err_* hold until the next start or reset.
- Latency: start sampled at edge 0 → done high for one cycle, 2^WIDTH*(SETTLE+1)+1 cycles later. Defaults: 33 cycles.
- start while busy or in DONE: ignored.
- abort (in any non-IDLE state):
  - Next state IDLE; done stays 0; pass=0.
  - err_count and first_err_* retain their partial values.
  - abort has priority over the CHECK-cycle updates.
- start and abort both high in IDLE: abort wins; remain IDLE.
- err_count needs WIDTH+1 bits (maximum 2^WIDTH); it cannot overflow.

Decomposition:
- Shared package (neg_pkg) holds:
  - the state encoding constants S_IDLE/S_WAIT/S_CHECK/S_DONE (2-bit);
  - a function neg2c(WIDTH-bit) returning ~x+1, reused by any future negate/subtract stages.
- No sub-module: the FSM, operand counter, settle counter and error registers live in one module.
- The board top instantiates this block alongside the negator, connecting a_out→a and b→b_in.

Test Plan:
- Golden negator model on b_in, start pulsed once → busy for 32 cycles; done at cycle 33; pass=1; err_count=0; first_err_valid=0.
- b_in stuck at 0 → err_count=15 (only a=0 matches); first_err_a=1; pass=0.
- Faulty model b_in=~a_out (missing +1) → err_count=16; first_err_a=0; pass=0.
- Faulty model b_in=a_out → matches only at a=0 and a=8; err_count=14; first_err_a=1.
- start re-pulsed at cycle 10 of a sweep → ignored; done still at cycle 33; abort at cycle 12 → IDLE next cycle, done never pulses, busy=0.
- rst_n driven low at cycle 20 (asynchronous, mid-clock) → all outputs 0 immediately; after release, a new start completes a normal sweep with pass=1.
